uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4: number of byte-stream requesters; legal range 2..8.
REQ-002 Parameter HDR_BASE, default 8'hA0: header byte base value; bits [2:0] SHALL be zero.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: idle cycles allowed mid-packet before a forced release; minimum 2.
REQ-004 Clk  input  1  clock; all state updates on the rising edge.
REQ-005 Rst  input  1  reset, synchronous, active-high.
REQ-006 S_axis_tdata  input  NUM_SRC*8  per-source data byte; source i occupies bits [8i+7:8i].
REQ-007 S_axis_tvalid  input  NUM_SRC  per-source valid.
REQ-008 S_axis_tlast  input  NUM_SRC  per-source last byte of the packet.
REQ-009 S_axis_tready  output  NUM_SRC  per-source ready.
REQ-010 M_axis_tdata  output  8  byte to the UART transmitter.
REQ-011 M_axis_tvalid  output  1  byte valid to the transmitter.
REQ-012 M_axis_tready  input  1  transmitter ready.
REQ-013 Grant  output  NUM_SRC  registered one-hot current owner; all zeros when no source owns the stream.
REQ-014 Timeout_err  output  1  one-cycle pulse on a forced release.

Function
REQ-015 The FSM SHALL have the states IDLE, HEADER and PAYLOAD, held in one register.
REQ-016 IDLE, when any S_axis_tvalid is high: the arbiter SHALL register a grant to the first requesting source, searching round-robin from (last_owner+1) mod NUM_SRC, then go to HEADER.
REQ-017 IDLE, when no S_axis_tvalid is high: the state SHALL stay IDLE.
REQ-018 HEADER: M_axis_tvalid=1 and M_axis_tdata=HDR_BASE|owner_index.
REQ-019 HEADER: on M_axis_tvalid&M_axis_tready the state SHALL go to PAYLOAD.
REQ-020 HEADER: no S_axis_tready bit SHALL be high.
REQ-021 PAYLOAD: M_axis_tdata and M_axis_tvalid SHALL be combinational pass-through from the owner.
REQ-022 PAYLOAD: S_axis_tready[owner]=M_axis_tready; all other S_axis_tready bits SHALL be 0.
REQ-023 PAYLOAD: a transfer with the owner's tlast=1 SHALL return the state to IDLE, set last_owner=owner and clear Grant on the next cycle.
REQ-024 Packets SHALL never interleave; a grant SHALL change only in IDLE.
REQ-025 Outside PAYLOAD, S_axis_tready SHALL be all zeros; in IDLE, M_axis_tvalid SHALL be 0.
REQ-026 Timeout counter: increments each PAYLOAD cycle with the owner's tvalid=0, clears on any PAYLOAD transfer, and clears on entry to PAYLOAD.
REQ-027 When the timeout counter reaches TIMEOUT_CYCLES-1 with the owner's tvalid still 0, the next state SHALL be IDLE.
REQ-028 On a timeout release, Timeout_err=1 for exactly one cycle and last_owner=owner.
REQ-029 HEADER stalls (M_axis_tready=0) SHALL not time out.
REQ-030 A source that drops tvalid after a grant but before its header is accepted SHALL still receive its header; its payload is then subject to timeout.
REQ-031 Simultaneous requests from all sources: each source SHALL be served exactly once per NUM_SRC consecutive packets.

Reset
REQ-032 Rst SHALL set: state=IDLE, Grant=0, last_owner=NUM_SRC-1 (source 0 has first priority), timeout counter=0, Timeout_err=0.
REQ-033 During Rst, M_axis_tvalid=0 and S_axis_tready=0.
REQ-034 Rst asserted mid-packet SHALL abandon the packet without emitting further bytes.

Verification
REQ-035 After reset, src0 sends 2-byte packet {11,22}, M_tready=1 -> M stream A0,11,22; Grant=0001 for 3 cycles, then 0000.
REQ-036 All 4 sources request 1-byte packets continuously -> headers A0,A1,A2,A3,A0 in order; no byte from a non-owner appears.
REQ-037 src2 packet of 3 bytes with M_tready toggling 1/0 -> A2 plus 3 bytes, each byte held stable while valid&!ready; S_axis_tready[2] mirrors M_tready only in PAYLOAD.
REQ-038 src1 granted, header sent, tvalid low for TIMEOUT_CYCLES cycles -> Timeout_err single pulse, state IDLE, next pending src2 granted ahead of src1.
REQ-039 Rst pulsed during PAYLOAD of src3 -> next cycle M_tvalid=0, Grant=0; a subsequent request from src3 and src0 grants src0 first.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
//   Byte-stream bundle between NUM_SRC requesters and one UART transmitter.
//   S_axis_* : per-source streams (source i uses tdata[8i+7:8i], bit i of valid/last/ready)
//   M_axis_* : merged stream towards the transmitter
//   modport master : arbiter view (drives M_axis_tdata/tvalid and S_axis_tready)
//   modport slave  : environment view (sources and transmitter)
interface uart_tx_arbiter_if #(
  parameter int NUM_SRC = 4
);
  logic [NUM_SRC*8-1:0] S_axis_tdata;
  logic [NUM_SRC-1:0]   S_axis_tvalid;
  logic [NUM_SRC-1:0]   S_axis_tlast;
  logic [NUM_SRC-1:0]   S_axis_tready;
  logic [7:0]           M_axis_tdata;
  logic                 M_axis_tvalid;
  logic                 M_axis_tready;

  modport master (
    input  S_axis_tdata, S_axis_tvalid, S_axis_tlast, M_axis_tready,
    output S_axis_tready, M_axis_tdata, M_axis_tvalid
  );

  modport slave (
    output S_axis_tdata, S_axis_tvalid, S_axis_tlast, M_axis_tready,
    input  S_axis_tready, M_axis_tdata, M_axis_tvalid
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Merges NUM_SRC byte streams into one UART transmit stream. Each packet is
//   prefixed with a header byte HDR_BASE|owner_index; packets never interleave.
//   Ownership is handed out round-robin; an owner that goes silent mid-packet
//   for TIMEOUT_CYCLES cycles is forcibly released.
// Ports
//   Clk         : clock, rising edge
//   Rst         : synchronous active-high reset
//   bus         : uart_tx_arbiter_if.master (S_axis_* sources, M_axis_* transmitter)
//   Grant       : registered one-hot owner, zero when nobody owns the stream
//   Timeout_err : one-cycle pulse when an owner is released by timeout
// Parameters
//   NUM_SRC (2..8), HDR_BASE (bits [2:0] must be zero), TIMEOUT_CYCLES (>= 2)
module uart_tx_arbiter #(
  parameter int         NUM_SRC        = 4,
  parameter logic [7:0] HDR_BASE       = 8'hA0,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                     Clk,
  input  logic                     Rst,
  uart_tx_arbiter_if.master        bus,
  output logic [NUM_SRC-1:0]       Grant,
  output logic                     Timeout_err
);
  localparam int IW = $clog2(NUM_SRC);
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [IW-1:0]        last_owner_q, last_owner_d;
  logic [NUM_SRC-1:0]   grant_q, grant_d;
  logic [CW-1:0]        tmo_cnt_q, tmo_cnt_d;
  logic                 timeout_err_q, timeout_err_d;

  logic [7:0]           src_data [NUM_SRC];
  logic [IW-1:0]        rr_cand;
  logic [IW-1:0]        rr_sel;
  logic                 rr_found;
  logic                 owner_valid;
  logic                 owner_last;
  logic [7:0]           m_tdata;
  logic                 m_tvalid;
  logic [NUM_SRC-1:0]   s_tready;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
      assign src_data[gi] = bus.S_axis_tdata[8*gi +: 8];
    end
  endgenerate

  // Round-robin search starting just after the previous owner, so the source
  // that was served last has the lowest priority next time.
  always_comb begin
    rr_cand  = '0;
    rr_sel   = '0;
    rr_found = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      rr_cand = IW'((int'(last_owner_q) + k) % NUM_SRC);
      if (!rr_found && bus.S_axis_tvalid[rr_cand]) begin
        rr_found = 1'b1;
        rr_sel   = rr_cand;
      end
    end
  end

  assign owner_valid = bus.S_axis_tvalid[owner_q];
  assign owner_last  = bus.S_axis_tlast[owner_q];

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    grant_d       = grant_q;
    tmo_cnt_d     = tmo_cnt_q;
    timeout_err_d = 1'b0;
    m_tdata       = 8'h00;
    m_tvalid      = 1'b0;
    s_tready      = '0;

    unique case (state_q)
      IDLE: begin
        tmo_cnt_d = '0;
        if (rr_found) begin
          owner_d = rr_sel;
          grant_d = NUM_SRC'(1) << rr_sel;
          state_d = HEADER;
        end
      end
      HEADER: begin
        // The header goes out regardless of the owner's current tvalid; the
        // counter only runs in PAYLOAD, so a stalled header never times out.
        m_tvalid = 1'b1;
        m_tdata  = HDR_BASE | 8'(owner_q);
        if (bus.M_axis_tready) begin
          state_d   = PAYLOAD;
          tmo_cnt_d = '0;
        end
      end
      PAYLOAD: begin
        m_tvalid          = owner_valid;
        m_tdata           = src_data[owner_q];
        s_tready[owner_q] = bus.M_axis_tready;
        if (owner_valid && bus.M_axis_tready) begin
          tmo_cnt_d = '0;
          if (owner_last) begin
            state_d      = IDLE;
            grant_d      = '0;
            last_owner_d = owner_q;
          end
        end else if (!owner_valid) begin
          if (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            state_d       = IDLE;
            grant_d       = '0;
            last_owner_d  = owner_q;
            timeout_err_d = 1'b1;
            tmo_cnt_d     = '0;
          end else begin
            tmo_cnt_d = tmo_cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    // Nothing may be offered or accepted while reset is held.
    if (Rst) begin
      m_tvalid = 1'b0;
      s_tready = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      last_owner_q  <= IW'(NUM_SRC - 1);
      grant_q       <= '0;
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
      grant_q       <= grant_d;
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.M_axis_tdata  = m_tdata;
  assign bus.M_axis_tvalid = m_tvalid;
  assign bus.S_axis_tready = s_tready;
  assign Grant             = grant_q;
  assign Timeout_err       = timeout_err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Directed and randomized checks of uart_tx_arbiter. Sources are byte queues
//   held in the bench; the expected transmit stream is built from the
//   round-robin rule over sources with pending packets.
module tb_uart_tx_arbiter;
  localparam int         N   = 4;
  localparam logic [7:0] HDR = 8'hA0;
  localparam int         TMO = 16;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic [N-1:0] Grant;
  logic         Timeout_err;

  uart_tx_arbiter_if #(.NUM_SRC(N)) bus ();

  uart_tx_arbiter #(.NUM_SRC(N), .HDR_BASE(HDR), .TIMEOUT_CYCLES(TMO)) dut (
    .Clk(Clk), .Rst(Rst), .bus(bus), .Grant(Grant), .Timeout_err(Timeout_err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] data;
    int         owner;
    bit         is_hdr;
    bit         last;
  } exp_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [8:0] src_mem [N][1024];   // {last, data}
  int         rd_ptr [N];
  int         wr_ptr [N];
  bit         mute [N];
  int         gap_run [N];
  bit         gap_en = 0, ready_rand = 0, ready_toggle = 0, ready_val = 1;
  exp_t       exp_q[$];
  logic [7:0] hdr_seen[$];
  logic [N-1:0] grant_hist[$];
  int         model_last = N - 1;
  bit         hdr_done = 0;
  int         cur_owner = 0;
  int         tmo_pulses = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input int s, input logic [7:0] d, input bit last);
    src_mem[s][wr_ptr[s]] = {last, d};
    wr_ptr[s]++;
  endtask

  function automatic bit any_pending();
    for (int i = 0; i < N; i++) if (rd_ptr[i] != wr_ptr[i] && !mute[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Next packet = first source after the previous owner with a packet waiting.
  function automatic void model_next();
    int s;
    for (int k = 1; k <= N; k++) begin
      s = (model_last + k) % N;
      if (rd_ptr[s] != wr_ptr[s]) begin
        exp_q.push_back('{data: HDR | 8'(s), owner: s, is_hdr: 1'b1, last: 1'b0});
        for (int p = rd_ptr[s]; p < wr_ptr[s]; p++) begin
          exp_q.push_back('{data: src_mem[s][p][7:0], owner: s, is_hdr: 1'b0, last: src_mem[s][p][8]});
          if (src_mem[s][p][8]) break;
        end
        model_last = s;
        return;
      end
    end
  endfunction

  // One clock: drive at posedge+1, check at negedge, return at next posedge+1.
  task automatic cycle();
    logic [N-1:0] exp_rdy;
    exp_t         e;
    for (int i = 0; i < N; i++) begin
      bit has, gap;
      has = (rd_ptr[i] != wr_ptr[i]);
      gap = 1'b0;
      if (gap_en && Grant[i] && gap_run[i] < 3 && $urandom_range(0, 3) == 0) gap = 1'b1;
      gap_run[i] = gap ? gap_run[i] + 1 : 0;
      bus.S_axis_tvalid[i]     = has && !gap && !mute[i];
      bus.S_axis_tdata[8*i +: 8] = has ? src_mem[i][rd_ptr[i]][7:0] : 8'h00;
      bus.S_axis_tlast[i]      = has ? src_mem[i][rd_ptr[i]][8] : 1'b0;
    end
    if (ready_toggle)    ready_val = ~ready_val;
    else if (ready_rand) ready_val = ($urandom_range(0, 3) != 0);
    else                 ready_val = 1'b1;
    bus.M_axis_tready = ready_val;

    @(negedge Clk);
    grant_hist.push_back(Grant);
    if (Timeout_err) begin
      tmo_pulses++;
      exp_q.delete();   // the rest of the aborted packet never goes out
      hdr_done = 1'b0;
    end
    if (Rst) begin
      check("rst_m_tvalid", 32'(bus.M_axis_tvalid), 0);
      check("rst_s_tready", 32'(bus.S_axis_tready), 0);
    end else begin
      exp_rdy = hdr_done ? (N'(ready_val) << cur_owner) : '0;
      check("s_tready", 32'(bus.S_axis_tready), 32'(exp_rdy));
      if (prev_stall && !gap_en) begin
        check("stall_valid", 32'(bus.M_axis_tvalid), 1);
        check("stall_data", 32'(bus.M_axis_tdata), 32'(prev_data));
      end
      if (bus.M_axis_tvalid && bus.M_axis_tready) begin
        if (exp_q.size() == 0) model_next();
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $error("FAIL stray_byte: observed %0h expected no transfer", bus.M_axis_tdata);
        end else begin
          e = exp_q.pop_front();
          check("m_tdata", 32'(bus.M_axis_tdata), 32'(e.data));
          check("grant", 32'(Grant), 32'(1) << e.owner);
          if (e.is_hdr) begin
            hdr_done  = 1'b1;
            cur_owner = e.owner;
            hdr_seen.push_back(bus.M_axis_tdata);
          end else if (e.last) begin
            hdr_done = 1'b0;
          end
        end
      end
    end
    prev_stall = bus.M_axis_tvalid && !bus.M_axis_tready && !Rst;
    prev_data  = bus.M_axis_tdata;
    for (int i = 0; i < N; i++)
      if (bus.S_axis_tvalid[i] && bus.S_axis_tready[i]) rd_ptr[i]++;
    if (Rst) begin
      // Reset abandons everything: sources drop their packets, model restarts.
      exp_q.delete();
      hdr_done   = 1'b0;
      model_last = N - 1;
      prev_stall = 1'b0;
      for (int i = 0; i < N; i++) rd_ptr[i] = wr_ptr[i];
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic run_drain(input int budget, input string tag);
    int c = 0;
    while ((exp_q.size() > 0 || any_pending() || hdr_done) && c < budget) begin
      cycle();
      c++;
    end
    n_tests++;
    assert (c < budget) else begin
      n_fail++;
      $error("FAIL %s_drain: observed %0d cycles expected below %0d", tag, c, budget);
    end
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    cycle();
    cycle();
    Rst = 1'b0;
    check("rst_grant", 32'(Grant), 0);
    check("rst_timeout_err", 32'(Timeout_err), 0);
    check("rst_idle_m_tvalid", 32'(bus.M_axis_tvalid), 0);
  endtask

  initial begin
    int c;
    logic [N-1:0] exp_hist [5];
    logic [7:0]   exp_hdrs [8];
    for (int i = 0; i < N; i++) begin
      rd_ptr[i] = 0; wr_ptr[i] = 0; mute[i] = 1'b0; gap_run[i] = 0;
    end
    bus.S_axis_tdata = '0; bus.S_axis_tvalid = '0; bus.S_axis_tlast = '0; bus.M_axis_tready = 1'b0;
    @(posedge Clk);
    #1;
    do_reset();

    // src0 two-byte packet: A0,11,22 and Grant high for exactly three cycles
    push_byte(0, 8'h11, 1'b0);
    push_byte(0, 8'h22, 1'b1);
    grant_hist.delete();
    run_drain(40, "two_byte");
    cycle();
    exp_hist = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
    check("grant_hist_len", grant_hist.size(), 5);
    if (grant_hist.size() == 5)
      for (int i = 0; i < 5; i++) check("grant_hist", 32'(grant_hist[i]), 32'(exp_hist[i]));

    // all sources with back-to-back one-byte packets: strict rotation
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < N; s++) push_byte(s, 8'(8'h10 * (s + 1) + r), 1'b1);
    hdr_seen.delete();
    run_drain(200, "rotation");
    exp_hdrs = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
    check("rotation_hdr_count", hdr_seen.size(), 8);
    if (hdr_seen.size() == 8)
      for (int i = 0; i < 8; i++) check("rotation_hdr", 32'(hdr_seen[i]), 32'(exp_hdrs[i]));

    // src2 three bytes with transmitter ready toggling
    do_reset();
    ready_toggle = 1'b1;
    push_byte(2, 8'h5A, 1'b0);
    push_byte(2, 8'hC3, 1'b0);
    push_byte(2, 8'h7E, 1'b1);
    hdr_seen.delete();
    run_drain(60, "toggle");
    ready_toggle = 1'b0;
    check("toggle_hdr", hdr_seen.size() > 0 ? 32'(hdr_seen[0]) : 32'hFFFF, 32'hA2);

    // src1 goes silent after its header; src2 waits and must win next
    do_reset();
    push_byte(1, 8'h55, 1'b1);
    c = 0;
    while (!hdr_done && c < 20) begin cycle(); c++; end
    check("tmo_hdr_sent", 32'(hdr_done), 1);
    mute[1] = 1'b1;
    push_byte(2, 8'h66, 1'b1);
    tmo_pulses = 0;
    c = 0;
    while (tmo_pulses == 0 && c < TMO + 10) begin
      if (c == TMO) mute[1] = 1'b0;
      cycle();
      c++;
    end
    mute[1] = 1'b0;
    check("tmo_latency", c, TMO + 1);
    hdr_seen.delete();
    run_drain(80, "after_tmo");
    check("tmo_pulse_count", tmo_pulses, 1);
    check("after_tmo_hdr_count", hdr_seen.size(), 2);
    if (hdr_seen.size() == 2) begin
      check("after_tmo_first", 32'(hdr_seen[0]), 32'hA2);
      check("after_tmo_second", 32'(hdr_seen[1]), 32'hA1);
    end

    // reset in the middle of a src3 payload
    do_reset();
    for (int j = 0; j < 4; j++) push_byte(3, 8'(8'h31 + j), j == 3);
    c = 0;
    while (!(hdr_done && exp_q.size() == 3) && c < 30) begin cycle(); c++; end
    check("mid_pkt_reached", 32'(hdr_done && exp_q.size() == 3), 1);
    Rst = 1'b1;
    cycle();
    Rst = 1'b0;
    check("post_rst_grant", 32'(Grant), 0);
    check("post_rst_m_tvalid", 32'(bus.M_axis_tvalid), 0);
    push_byte(3, 8'h3A, 1'b1);
    push_byte(0, 8'h0A, 1'b1);
    hdr_seen.delete();
    run_drain(60, "post_rst");
    check("post_rst_hdr_count", hdr_seen.size(), 2);
    if (hdr_seen.size() == 2) begin
      check("post_rst_first", 32'(hdr_seen[0]), 32'hA0);
      check("post_rst_second", 32'(hdr_seen[1]), 32'hA3);
    end

    // randomized packets, random backpressure and short source gaps
    do_reset();
    gap_en = 1'b1;
    ready_rand = 1'b1;
    tmo_pulses = 0;
    for (int s = 0; s < N; s++) begin
      int npk;
      npk = $urandom_range(1, 6);
      for (int p = 0; p < npk; p++) begin
        int len;
        len = $urandom_range(1, 4);
        for (int j = 0; j < len; j++) push_byte(s, 8'($urandom), j == len - 1);
      end
    end
    run_drain(3000, "random");
    check("random_no_timeout", tmo_pulses, 0);
    gap_en = 1'b0;
    ready_rand = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
endmodule
